instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 151 +++++++++++++++
 tb/tb_instruction_fetch.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch sequencer between CPU core and instruction_medium
//
// Holds the program counter, requests one instruction at a time from the
// medium, waits SETTLE valid cycles for the BRAM pipeline to settle, then
// buffers {instruction, pc} in a DEPTH-entry FIFO that feeds decode.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   mem_addr_out          fetch address to the medium (held between requests)
//   mem_ready_out         one-cycle request strobe to the medium
//   mem_instruction_in    instruction word from the medium
//   mem_valid_in          medium data valid
//   instr_out/instr_pc_out FIFO head instruction and its address
//   instr_valid_out       FIFO non-empty
//   instr_ready_in        decode accepts the head entry
//   jump_valid_in/jump_addr_in one-cycle redirect request and target
//   halt_in               level; blocks new requests while high
//   pc_out                address of the next instruction to request
module instruction_fetch #(
  parameter int ADDRS    = 256,
  parameter int OP_SIZE  = 8,
  parameter int SETTLE   = 3,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0,
  localparam int ADDR_SIZE = $clog2(ADDRS)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  output logic [ADDR_SIZE-1:0] mem_addr_out,
  output logic                 mem_ready_out,
  input  logic [OP_SIZE-1:0]   mem_instruction_in,
  input  logic                 mem_valid_in,
  output logic [OP_SIZE-1:0]   instr_out,
  output logic [ADDR_SIZE-1:0] instr_pc_out,
  output logic                 instr_valid_out,
  input  logic                 instr_ready_in,
  input  logic                 jump_valid_in,
  input  logic [ADDR_SIZE-1:0] jump_addr_in,
  input  logic                 halt_in,
  output logic [ADDR_SIZE-1:0] pc_out
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [ADDR_SIZE-1:0] PC0     = ADDR_SIZE'(RESET_PC);
  localparam logic [ADDR_SIZE-1:0] PC_LAST = ADDR_SIZE'(ADDRS - 1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(SETTLE - 1);
  localparam logic [NW-1:0]        FULL     = NW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   pc_q, pc_d;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          head_q, tail_q;
  logic [NW-1:0]          count_q, count_after;
  logic [OP_SIZE-1:0]     fifo_op [DEPTH];
  logic [ADDR_SIZE-1:0]   fifo_pc [DEPTH];

  logic pop, capture, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop     = (count_q != '0) && instr_ready_in;
  assign capture = (state_q == S_WAIT) && mem_valid_in && (cnt_q == CNT_LAST);
  // A jump discards the captured word; the full check never trips in normal
  // operation because a request is only issued with a free slot.
  assign push    = capture && !jump_valid_in && ((count_q < FULL) || pop);

  always_comb begin
    count_after = count_q;
    if (push) count_after = count_after + NW'(1);
    if (pop)  count_after = count_after - NW'(1);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if ((count_q < FULL) && !halt_in) state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid_in) cnt_d = cnt_q + CW'(1);
        if (capture) begin
          pc_d    = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
          state_d = ((count_after < FULL) && !halt_in) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (jump_valid_in) begin
      state_d = S_IDLE;
      pc_d    = jump_addr_in;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      pc_q    <= PC0;
      addr_q  <= PC0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_op[i] <= '0;
        fifo_pc[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      // Load the address as the request is entered so mem_addr_out is a
      // plain register and stays put until the next request.
      if (state_d == S_REQ) addr_q <= pc_d;
      if (jump_valid_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          fifo_op[tail_q] <= mem_instruction_in;
          fifo_pc[tail_q] <= pc_q;
          tail_q          <= ptr_inc(tail_q);
        end
        if (pop) head_q <= ptr_inc(head_q);
        count_q <= count_after;
      end
    end
  end

  assign mem_ready_out   = (state_q == S_REQ);
  assign mem_addr_out    = addr_q;
  assign instr_out       = fifo_op[head_q];
  assign instr_pc_out    = fifo_pc[head_q];
  assign instr_valid_out = (count_q != '0);
  assign pc_out          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam int SETTLE = 3;
  localparam int DEPTH  = 2;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] mem_addr_out;
  logic       mem_ready_out;
  logic [7:0] mem_instruction_in = 8'h00;
  logic       mem_valid_in = 1'b0;
  logic [7:0] instr_out;
  logic [7:0] instr_pc_out;
  logic       instr_valid_out;
  logic       instr_ready_in = 1'b1;
  logic       jump_valid_in = 1'b0;
  logic [7:0] jump_addr_in = 8'h00;
  logic       halt_in = 1'b0;
  logic [7:0] pc_out;

  instruction_fetch #(
    .ADDRS(256), .OP_SIZE(8), .SETTLE(SETTLE), .DEPTH(DEPTH), .RESET_PC(0)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .mem_addr_out(mem_addr_out), .mem_ready_out(mem_ready_out),
    .mem_instruction_in(mem_instruction_in), .mem_valid_in(mem_valid_in),
    .instr_out(instr_out), .instr_pc_out(instr_pc_out),
    .instr_valid_out(instr_valid_out), .instr_ready_in(instr_ready_in),
    .jump_valid_in(jump_valid_in), .jump_addr_in(jump_addr_in),
    .halt_in(halt_in), .pc_out(pc_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  int base = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Medium model: data valid two cycles after the request (plus 'extra'),
  // held until the next request.
  logic [7:0] m_addr = 8'h00;
  int         m_wait = 0;
  bit         m_pend = 1'b0;
  int         extra  = 0;
  always @(posedge clk_in) begin
    if (mem_ready_out) begin
      m_addr       <= mem_addr_out;
      m_wait       <= extra;
      m_pend       <= 1'b1;
      mem_valid_in <= 1'b0;
    end else if (m_pend) begin
      if (m_wait == 0) begin
        mem_valid_in       <= 1'b1;
        mem_instruction_in <= mem_f(m_addr);
        m_pend             <= 1'b0;
      end else begin
        m_wait <= m_wait - 1;
      end
    end
  end

  // Transaction logs (cycle numbers relative to reset release) and a
  // program-order scoreboard: requests and delivered words must follow
  // pc, pc+1, ... restarting at the target after every jump.
  int         req_cyc[$];
  logic [7:0] req_addr[$];
  int         pop_cyc[$];
  logic [7:0] pop_op[$];
  logic [7:0] pop_pc[$];
  logic [7:0] exp_req = 8'h00;
  logic [7:0] exp_pop = 8'h00;
  logic       prev_halt = 1'b0;
  logic       prev_jump = 1'b0;
  int         npops = 0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      exp_req   = 8'h00;
      exp_pop   = 8'h00;
      prev_jump = 1'b0;
      prev_halt = halt_in;
    end else begin
      if (prev_jump) check("flush_after_jump", instr_valid_out, 0);
      if (mem_ready_out) begin
        check("req_addr", mem_addr_out, exp_req);
        check("req_while_halted", prev_halt, 0);
        req_cyc.push_back(cyc - base);
        req_addr.push_back(mem_addr_out);
        exp_req = exp_req + 8'd1;
      end
      if (instr_valid_out && instr_ready_in) begin
        check("pop_pc", instr_pc_out, exp_pop);
        check("pop_op", instr_out, mem_f(exp_pop));
        pop_cyc.push_back(cyc - base);
        pop_op.push_back(instr_out);
        pop_pc.push_back(instr_pc_out);
        exp_pop = exp_pop + 8'd1;
        npops++;
      end
      if (jump_valid_in) begin
        exp_req = jump_addr_in;
        exp_pop = jump_addr_in;
      end
      prev_jump = jump_valid_in;
      prev_halt = halt_in;
    end
  end

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_logs;
    req_cyc.delete(); req_addr.delete();
    pop_cyc.delete(); pop_op.delete(); pop_pc.delete();
  endtask

  // Reset release happens in "cycle 1"; the first request is due in cycle 2.
  task automatic do_reset;
    rst_in = 1'b1;
    repeat (2) step;
    rst_in = 1'b0;
    base = cyc - 1;
    clear_logs();
  endtask

  task automatic wait_reqs(input int n);
    int k = 0;
    while (req_cyc.size() < n && k < 200) begin
      step;
      k++;
    end
    if (req_cyc.size() < n) check("wait_req_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, mem_ready_out, 0);
    check({tag, "_addr"}, mem_addr_out, 0);
    check({tag, "_pc"}, pc_out, 0);
    check({tag, "_valid"}, instr_valid_out, 0);
    check({tag, "_op"}, instr_out, 0);
    check({tag, "_ipc"}, instr_pc_out, 0);
  endtask

  initial begin
    int j, t2, p, h, n0, idx, found, rpops;
    logic [7:0] a, e;

    step; step;
    check_reset_outputs("reset");

    // Reset then run
    instr_ready_in = 1'b1;
    do_reset();
    repeat (20) step;
    check("run_nreq", req_cyc.size() >= 3, 1);
    check("run_npop", pop_cyc.size() >= 3, 1);
    for (int i = 0; i < 3; i++) begin
      if (i < req_cyc.size()) begin
        check("run_req_cyc", req_cyc[i], 2 + 5 * i);
        check("run_req_addr", req_addr[i], i);
      end
      if (i < pop_cyc.size()) begin
        check("run_pop_cyc", pop_cyc[i], 7 + 5 * i);
        check("run_pop_op", pop_op[i], mem_f(8'(i)));
        check("run_pop_pc", pop_pc[i], i);
      end
    end

    // Backpressure
    instr_ready_in = 1'b0;
    do_reset();
    repeat (30) step;
    check("bp_nreq", req_cyc.size(), DEPTH);
    check("bp_valid", instr_valid_out, 1);
    check("bp_head_pc", instr_pc_out, 0);
    check("bp_head_op", instr_out, 8'hA5);
    instr_ready_in = 1'b1;
    p = cyc - base;
    step;
    instr_ready_in = 1'b0;
    repeat (6) step;
    check("bp_pop_cyc", (pop_cyc.size() > 0) ? pop_cyc[0] : -1, p);
    check("bp_nreq_after", req_cyc.size(), 3);
    if (req_cyc.size() >= 3) begin
      check("bp_req_within2", (req_cyc[2] - p >= 1) && (req_cyc[2] - p <= 2), 1);
      check("bp_req_addr", req_addr[2], 2);
    end

    // Jump mid-WAIT, two cycles after the request for address 3
    instr_ready_in = 1'b1;
    do_reset();
    wait_reqs(4);
    if (req_cyc.size() >= 4) check("jmp_req3_addr", req_addr[3], 3);
    step;
    jump_valid_in = 1'b1; jump_addr_in = 8'h40;
    j = cyc - base;
    step;
    jump_valid_in = 1'b0;
    repeat (20) step;
    idx = -1;
    for (int i = 0; i < req_cyc.size(); i++) if (idx < 0 && req_cyc[i] > j) idx = i;
    check("jmp_req_found", idx >= 0, 1);
    if (idx >= 0) begin
      check("jmp_req_cyc", req_cyc[idx], j + 2);
      check("jmp_req_addr", req_addr[idx], 8'h40);
    end
    idx = -1;
    for (int i = 0; i < pop_cyc.size(); i++) if (idx < 0 && pop_cyc[i] > j) idx = i;
    check("jmp_pop_found", idx >= 0, 1);
    if (idx >= 0) begin
      check("jmp_pop_pc", pop_pc[idx], 8'h40);
      check("jmp_pop_op", pop_op[idx], mem_f(8'h40));
    end

    // Jump on the capture cycle with a simultaneous pop
    instr_ready_in = 1'b0;
    do_reset();
    wait_reqs(2);
    t2 = (req_cyc.size() >= 2) ? req_cyc[1] : 0;
    repeat (SETTLE) step;
    check("cap_cycle_align", cyc - base, t2 + 1 + SETTLE);
    instr_ready_in = 1'b1;
    jump_valid_in = 1'b1; jump_addr_in = 8'h80;
    j = cyc - base;
    step;
    jump_valid_in = 1'b0;
    @(negedge clk_in);
    check("cap_empty_j1", instr_valid_out, 0);
    repeat (20) step;
    found = 0;
    for (int i = 0; i < pop_cyc.size(); i++) if (pop_cyc[i] == j && pop_pc[i] == 8'h00) found = 1;
    check("cap_pop_done", found, 1);
    idx = -1;
    for (int i = 0; i < pop_cyc.size(); i++) if (idx < 0 && pop_cyc[i] > j) idx = i;
    check("cap_next_pc", (idx >= 0) ? pop_pc[idx] : 8'hFF, 8'h80);

    // Wrap-around from 254
    repeat (5) step;
    jump_valid_in = 1'b1; jump_addr_in = 8'hFE;
    j = cyc - base;
    step;
    jump_valid_in = 1'b0;
    repeat (35) step;
    idx = -1;
    for (int i = 0; i < pop_cyc.size(); i++) if (idx < 0 && pop_cyc[i] > j) idx = i;
    check("wrap_found", (idx >= 0) && (idx + 4 <= pop_cyc.size()), 1);
    if ((idx >= 0) && (idx + 4 <= pop_cyc.size())) begin
      e = 8'hFE;
      for (int i = 0; i < 4; i++) begin
        check("wrap_pc", pop_pc[idx + i], e);
        e = e + 8'd1;
      end
    end

    // Halt during WAIT: in-flight fetch completes, then no request
    n0 = req_cyc.size();
    wait_reqs(n0 + 1);
    a = (req_addr.size() > n0) ? req_addr[n0] : 8'h00;
    halt_in = 1'b1;
    repeat (25) step;
    check("halt_nreq", req_cyc.size(), n0 + 1);
    check("halt_delivered", (pop_pc.size() > 0) ? pop_pc[pop_pc.size() - 1] : 9'h100, a);
    check("halt_pc_out", pc_out, 8'(a + 8'd1));
    check("halt_empty", instr_valid_out, 0);
    halt_in = 1'b0;
    h = cyc - base;
    repeat (8) step;
    check("halt_resume_n", req_cyc.size() >= n0 + 2, 1);
    if (req_cyc.size() >= n0 + 2) begin
      check("halt_resume_cyc", req_cyc[n0 + 1], h + 1);
      check("halt_resume_addr", req_addr[n0 + 1], 8'(a + 8'd1));
    end

    // Asynchronous reset mid-WAIT
    n0 = req_cyc.size();
    wait_reqs(n0 + 1);
    step;
    #2;
    rst_in = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    step; step;
    rst_in = 1'b0;
    base = cyc - 1;
    clear_logs();
    repeat (20) step;
    check("post_rst_req_cyc", (req_cyc.size() > 0) ? req_cyc[0] : -1, 2);
    check("post_rst_req_addr", (req_addr.size() > 0) ? req_addr[0] : 9'h100, 0);
    check("post_rst_pop_pc", (pop_pc.size() > 0) ? pop_pc[0] : 9'h100, 0);

    // Randomized traffic; the scoreboard checks every request and pop
    rpops = npops;
    for (int i = 0; i < 3000; i++) begin
      instr_ready_in = ($urandom_range(9) < 7);
      if (halt_in) halt_in = ($urandom_range(4) != 0);
      else         halt_in = ($urandom_range(29) == 0);
      jump_valid_in = ($urandom_range(59) == 0);
      jump_addr_in  = 8'($urandom);
      extra         = $urandom_range(2);
      step;
    end
    jump_valid_in = 1'b0;
    halt_in = 1'b0;
    instr_ready_in = 1'b1;
    extra = 0;
    repeat (40) step;
    check("rand_progress", (npops - rpops) > 50, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
